register_bank: RTL

General-purpose register file and status-flag register for the single-cycle CPU. It sits directly upstream of the shifter and ALU: its two combinational read ports supply the shifter's `in` operand and the register-sourced shift amount. It captures one write-back result per clock, and it latches the carry/zero/sign/overflow flags produced by the ALU/shifter stage.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/flag_reg.sv | 27 ++
 rtl/register_bank.sv | 70 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: data/address widths and status-flag bit positions.
package cpu_pkg;

  localparam int WIDTH    = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/flag_reg.sv
// Status-flag register: loads {carry, zero, sign, overflow} when enabled, async clear.
module flag_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  flags_t flags_d,
  output flags_t flags_q
);

  flags_t flags_r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_r_q <= '0;
    end else if (en) begin
      flags_r_q[FLAG_C] <= flags_d[FLAG_C];
      flags_r_q[FLAG_Z] <= flags_d[FLAG_Z];
      flags_r_q[FLAG_S] <= flags_d[FLAG_S];
      flags_r_q[FLAG_V] <= flags_d[FLAG_V];
    end
  end

  assign flags_q = flags_r_q;

endmodule

// File: rtl/register_bank.sv
// General-purpose register file with two combinational read ports, optional
// write-to-read bypass and hard-wired zero register, plus the flag register.
module register_bank
  import cpu_pkg::*;
#(
  parameter int WIDTH    = cpu_pkg::WIDTH,
  parameter int NUM_REGS = cpu_pkg::NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic [4:0]        shamt_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              flag_en,
  input  logic [3:0]        flags_in,
  output logic [3:0]        flags
);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic             wr_ok;
  logic             zero_a, zero_b;
  logic             byp_a, byp_b;

  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // A bypass never fires for the zero register because wr_ok excludes it.
  always_comb begin
    zero_a = (ZERO_REG != 0) && (rd_addr_a == '0);
    zero_b = (ZERO_REG != 0) && (rd_addr_b == '0);
    byp_a  = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr_a);
    byp_b  = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr_b);

    if (byp_a)       rd_data_a = wr_data;
    else if (zero_a) rd_data_a = '0;
    else             rd_data_a = regs_q[rd_addr_a];

    if (byp_b)       rd_data_b = wr_data;
    else if (zero_b) rd_data_b = '0;
    else             rd_data_b = regs_q[rd_addr_b];
  end

  assign shamt_b = rd_data_b[4:0];

  flag_reg u_flag_reg (
    .clk     (clk),
    .rst     (rst),
    .en      (flag_en),
    .flags_d (flags_in),
    .flags_q (flags)
  );

endmodule
